// File: rtl/arcade_video_timer.sv
// Horizontal/vertical video timing generator with a pixel clock enable and cocktail flip.
// Also provides a latched vertical-blank interrupt with acknowledge.
module arcade_video_timer #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned HW           = 9,
  parameter int unsigned VW           = 9,
  parameter int unsigned H_TOTAL      = 384,
  parameter int unsigned H_ACTIVE     = 256,
  parameter int unsigned H_SYNC_START = 288,
  parameter int unsigned H_SYNC_END   = 320,
  parameter int unsigned V_TOTAL      = 264,
  parameter int unsigned V_ACTIVE     = 224,
  parameter int unsigned V_SYNC_START = 240,
  parameter int unsigned V_SYNC_END   = 248,
  parameter int unsigned IRQ_LINE     = 224
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          flip,
  input  logic          int_ack,
  output logic          pix_ce,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          n_hsync,
  output logic          n_vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic          n_irq,
  output logic          flip_q,
  output logic [7:0]    frame_cnt
);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $fatal(1, "arcade_video_timer: CLK_DIV out of range 1..16");
  end
  if (!(H_ACTIVE > 0 && H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
        H_SYNC_END <= H_TOTAL && H_TOTAL <= (1 << HW))) begin : g_bad_h
    $fatal(1, "arcade_video_timer: illegal horizontal timing");
  end
  if (!(V_ACTIVE > 0 && V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END &&
        V_SYNC_END <= V_TOTAL && V_TOTAL <= (1 << VW) && IRQ_LINE < V_TOTAL)) begin : g_bad_v
    $fatal(1, "arcade_video_timer: illegal vertical timing");
  end

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DivLast    = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VLast      = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] HFlipBase  = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] VFlipBase  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] IrqLine    = VW'(IRQ_LINE);
  // One extra bit so that a *_SYNC_END equal to 2^W still compares correctly.
  localparam logic [HW:0]   HActive    = (HW + 1)'(H_ACTIVE);
  localparam logic [HW:0]   HSyncStart = (HW + 1)'(H_SYNC_START);
  localparam logic [HW:0]   HSyncEnd   = (HW + 1)'(H_SYNC_END);
  localparam logic [VW:0]   VActive    = (VW + 1)'(V_ACTIVE);
  localparam logic [VW:0]   VSyncStart = (VW + 1)'(V_SYNC_START);
  localparam logic [VW:0]   VSyncEnd   = (VW + 1)'(V_SYNC_END);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d, hpos_q, hpos_d;
  logic [VW-1:0] vcnt_q, vcnt_d, vpos_q, vpos_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          pix_ce_q, hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
  logic          hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
  logic          line_q, line_d, frame_q, frame_d, nirq_q, nirq_d, flip_r_q, flip_d;
  logic          tick, h_wrap, v_wrap, irq_set;
  logic [HW:0]   hx;
  logic [VW:0]   vx;

  always_comb begin
    tick    = (div_q == DivLast);
    div_d   = tick ? '0 : div_q + 1'b1;
    h_wrap  = (hcnt_q == HLast);
    v_wrap  = (vcnt_q == VLast);
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    fcnt_d  = fcnt_q;
    if (tick) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) begin
        vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
        if (v_wrap) fcnt_d = fcnt_q + 8'd1;
      end
    end
    line_d  = tick && h_wrap;
    frame_d = tick && h_wrap && v_wrap;
    flip_d  = frame_d ? flip : flip_r_q;
    // Decodes are taken from the next counts so they line up with the counters.
    hx        = {1'b0, hcnt_d};
    vx        = {1'b0, vcnt_d};
    hsync_n_d = !(hx >= HSyncStart && hx < HSyncEnd);
    vsync_n_d = !(vx >= VSyncStart && vx < VSyncEnd);
    hblank_d  = (hx >= HActive);
    vblank_d  = (vx >= VActive);
    de_d      = !hblank_d && !vblank_d;
    hpos_d    = (flip_d && !hblank_d) ? HFlipBase - hcnt_d : hcnt_d;
    vpos_d    = (flip_d && !vblank_d) ? VFlipBase - vcnt_d : vcnt_d;
    // A new raise beats a coincident acknowledge.
    irq_set   = tick && h_wrap && (vcnt_d == IrqLine);
    nirq_d    = irq_set ? 1'b0 : (int_ack ? 1'b1 : nirq_q);
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      div_q     <= '0;
      pix_ce_q  <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      fcnt_q    <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
      de_q      <= 1'b1;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      nirq_q    <= 1'b1;
      flip_r_q  <= 1'b0;
    end else begin
      div_q     <= div_d;
      pix_ce_q  <= tick;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      fcnt_q    <= fcnt_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      de_q      <= de_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      nirq_q    <= nirq_d;
      flip_r_q  <= flip_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign n_hsync     = hsync_n_q;
  assign n_vsync     = vsync_n_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign n_irq       = nirq_q;
  assign flip_q      = flip_r_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: doc/arcade_video_timer.md
Name: arcade_video_timer

Overview:
- Parametrised horizontal/vertical video timing generator that replaces the fixed discrete-counter chains (divider, H counter, V counter, sync and blank flops) used in the board-level tops.
- Derives the pixel clock enable from the single system clock.
- Produces H/V counts, active-low syncs, blanking, display-enable and optionally flipped (cocktail) coordinates.
- Provides a latched vertical-blank interrupt with CPU acknowledge, feeding the 6502 irq_n input and the tile/bullet renderers.

Parameters:
- CLK_DIV, 4: clk cycles per pixel; allowed range 1..16.
- HW, 9: width of the horizontal counter and hpos.
- VW, 9: width of the vertical counter and vpos.
- H_TOTAL, 384: pixels per line.
- H_ACTIVE, 256: visible pixels, at hcnt 0..H_ACTIVE-1.
- H_SYNC_START, 288: first hcnt with n_hsync low.
- H_SYNC_END, 320: first hcnt after hsync.
- V_TOTAL, 264: lines per frame.
- V_ACTIVE, 224: visible lines.
- V_SYNC_START, 240: first vcnt with n_vsync low.
- V_SYNC_END, 248: first vcnt after vsync.
- IRQ_LINE, 224: vcnt at which the interrupt is raised.
- Legality (checked at elaboration; an illegal set is a fatal error):
  - 0 < H_ACTIVE < H_SYNC_START < H_SYNC_END <= H_TOTAL <= 2^HW.
  - The same ordering applies to the V_* parameters with 2^VW.
  - IRQ_LINE < V_TOTAL.

Ports:
- clk, in, 1: system clock.
- nRESET, in, 1: asynchronous active-low reset.
- flip, in, 1: cocktail flip request; sampled at frame start only.
- int_ack, in, 1: synchronous interrupt acknowledge, active high for one or more clk cycles.
- pix_ce, out, 1: pixel clock enable, high for one clk every CLK_DIV clks.
- hcnt, out, HW: raw horizontal count.
- vcnt, out, VW: raw vertical count.
- hpos, out, HW: horizontal coordinate, flip applied.
- vpos, out, VW: vertical coordinate, flip applied.
- n_hsync, out, 1: horizontal sync, active low.
- n_vsync, out, 1: vertical sync, active low.
- hblank, out, 1: horizontal blanking.
- vblank, out, 1: vertical blanking.
- de, out, 1: display enable, equal to !hblank & !vblank.
- line_start, out, 1: one-clk pulse on the pix_ce cycle where hcnt becomes 0.
- frame_start, out, 1: one-clk pulse on the pix_ce cycle where hcnt and vcnt both become 0.
- n_irq, out, 1: latched interrupt request, active low.
- flip_q, out, 1: flip value in effect for the current frame.
- frame_cnt, out, 8: free-running frame counter.

Behaviour:
- Reset (nRESET low, asynchronous; takes effect mid-line or mid-frame without waiting for an edge):
  - div_cnt=0, pix_ce=0, hcnt=0, vcnt=0, hpos=0, vpos=0.
  - n_hsync=1, n_vsync=1, hblank=0, vblank=0, de=1.
  - line_start=0, frame_start=0, n_irq=1, flip_q=0, frame_cnt=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_ce is registered, high in the cycle after div_cnt==CLK_DIV-1.
  - The first pix_ce occurs CLK_DIV clk edges after reset release.
  - CLK_DIV=1: pix_ce is held high from the first edge.
- Counters (update only on pix_ce cycles):
  - hcnt increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, vcnt increments and wraps from V_TOTAL-1 to 0.
  - On the vcnt wrap, frame_cnt increments, with modulo-256 wrap.
- Decoded outputs (registered, updated in the same clk as the counter they describe, so zero relative latency):
  - n_hsync = !(H_SYNC_START <= hcnt < H_SYNC_END).
  - n_vsync = !(V_SYNC_START <= vcnt < V_SYNC_END).
  - hblank = hcnt >= H_ACTIVE.
  - vblank = vcnt >= V_ACTIVE.
  - de = !hblank & !vblank.
- Pulses: line_start and frame_start are high only in the clk where pix_ce is high and the stated count condition holds.
- Flip:
  - flip_q <= flip when the new counts are (0,0) on a pix_ce cycle.
  - A mid-frame change of flip has no effect until the next frame start.
  - While flip_q=1 and hcnt < H_ACTIVE: hpos = H_ACTIVE-1-hcnt.
  - While flip_q=1 and vcnt < V_ACTIVE: vpos = V_ACTIVE-1-vcnt.
  - Otherwise (flip_q=0, or in blanking): hpos = hcnt and vpos = vcnt.
- Interrupt:
  - On the pix_ce cycle where counts become (hcnt=0, vcnt=IRQ_LINE), n_irq <= 0.
  - int_ack high sets n_irq <= 1 in any clk.
  - Ack and set in the same clk: set wins, n_irq=0.
  - n_irq stays low until acknowledged and is never re-raised more than once per frame.
- Arithmetic: all compares are unsigned; no counter ever exceeds TOTAL-1.

Test Plan:
- Bench parameters for scenarios 1–5: CLK_DIV=2, HW=VW=4, H_TOTAL=8, H_ACTIVE=5, H_SYNC 6..7, V_TOTAL=4, V_ACTIVE=3, V_SYNC 3..4, IRQ_LINE=3.
1. Release reset:
   - pix_ce is high on every 2nd clk from clk 2.
   - hcnt sequence is 1,2..7,0, with line_start high at hcnt=0.
   - vcnt steps 0→1 on that wrap.
   - A full frame takes 64 clks; frame_cnt reaches 1 after 64 clks.
2. Over one line:
   - n_hsync is low only at hcnt=6.
   - hblank is high for hcnt 5..7.
   - Over one frame, n_vsync is low only at vcnt=3 and vblank is high only at vcnt=3.
   - de is high for exactly 15 pixel slots per frame.
3. Interrupt timing:
   - n_irq falls on the pix_ce cycle where vcnt becomes 3 and hcnt becomes 0.
   - int_ack pulse 5 clks later → n_irq=1 on the next edge.
   - int_ack coincident with the set cycle → n_irq stays 0.
4. Flip:
   - flip=1 asserted mid-frame → hpos still equals hcnt until the next frame_start.
   - In the next frame, hcnt=0 gives hpos=4 and vcnt=2 gives vpos=0.
   - At hcnt=6, hpos=6.
5. Reset mid-line:
   - nRESET low at hcnt=4, vcnt=2 → all outputs take their reset values immediately, before the next clk edge.
   - After release, counting restarts from 0.
6. Default parameters, CLK_DIV=1:
   - pix_ce is constantly high.
   - One frame is 384×264 = 101376 clks.
   - The n_hsync low width is 32 clks; the n_vsync low width is 8 lines.
